alu_resp_tx: RTL and testbench
==============================

# alu_resp_tx

Response transmitter for the UART ALU: accepts one ALU result with its opcode over a valid/ready handshake. It frames the result as an 8-byte response packet and shifts the packet out on the UART TX pin as 8N1 serial data. It is the outbound counterpart of the command receive path and sits between the ALU datapath and the board `tx_o` pin.

## Interface
- `ClkFreqHz`, default 12_000_000: core clock frequency.
- `BaudRate`, default 115_200: serial bit rate.
- `ClksPerBit`, default `ClkFreqHz/BaudRate` (truncating integer division): cycles per serial bit; must be ≥ 2.
- `clk_i`  in  1  sole clock, rising edge.
- `rst_ni`  in  1  reset, synchronous, active-low.
- `opcode_i`  in  8  opcode echoed in byte 0 of the response.
- `result_i`  in  32  ALU result.
- `valid_i`  in  1  opcode/result valid.
- `ready_o`  out  1  block idle, can accept.
- `tx_o`  out  1  UART serial output; idle high.
- `busy_o`  out  1  packet in flight; equals `!ready_o`.

One clock; reset is synchronous and active-low.

## Operation
- Packet bytes, in order:
  - byte 0: `opcode`
  - byte 1: 0x00 (reserved)
  - byte 2: length LSB = 0x08
  - byte 3: length MSB = 0x00
  - bytes 4..7: `result` little-endian (byte 4 = `result[7:0]`)
- Each byte is sent as one start bit (0), 8 data bits LSB first, then one stop bit (1).
- Bytes go back-to-back: byte n+1's start bit immediately follows byte n's stop bit, with no idle gap.
- Accept: on a cycle with `valid_i && ready_o`, capture `opcode_i` and `result_i` into internal registers. Inputs are ignored afterwards until the next accept.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE → START on accept.
  - START → DATA after `ClksPerBit` cycles.
  - DATA → STOP after 8 bit periods.
  - STOP → START if byte index < 7 (index increments).
  - STOP → IDLE if byte index = 7.
- Counters:
  - Bit-period counter: 0..`ClksPerBit`-1, wraps.
  - Bit index: 0..7.
  - Byte index: 0..7.
- `valid_i` while busy: no effect; the upstream stage holds the data until `ready_o`.

## Timing
- Reset values: `tx_o`=1, `ready_o`=1, `busy_o`=0, FSM=IDLE, all counters 0.
- Reset asserted mid-packet: on the next rising edge `tx_o`=1 and FSM returns to IDLE. The partial packet is dropped and never resumed.
- Accept at edge T: `tx_o` goes to 0 (start bit) from edge T+1 and `ready_o` goes to 0 from edge T+1.
- Each bit holds exactly `ClksPerBit` cycles; a byte lasts 10·`ClksPerBit` cycles.
- The full packet lasts 80·`ClksPerBit` cycles, from edge T+1 to edge T+1+80·`ClksPerBit`. `ready_o` returns to 1 at that final edge.
- Back-to-back packets: an accept on the first ready cycle starts the next start bit one cycle later. The minimum idle-high gap between packets is therefore 1 cycle.
- `tx_o` is driven directly from a flop, with no combinational path from inputs (glitch-free pin).

## Structure
- Shared package `uart_alu_pkg` holds:
  - header constants: `RespLenLsb`=8'h08, `RespLenMsb`=8'h00, `RespReserved`=8'h00, `RespBytes`=8
  - FSM state enum `tx_state_e`
- Natural sub-module: `uart_tx_byte`, which handles the bit-level 8N1 shifter.
  - Ports: `byte_i`, `valid_i`, `ready_o`, `tx_o`, parameter `ClksPerBit`.
  - `alu_resp_tx` is the byte sequencer/packet framer feeding it.
  - With the split, the START/DATA/STOP states live in `uart_tx_byte`, and the top keeps IDLE/SEND plus the byte index.
- The target RTL size, including the sub-module, is about 200 lines.

## Test plan
All scenarios use `ClkFreqHz`=1_000_000 and `BaudRate`=100_000, so `ClksPerBit`=10.

- Reset: hold `rst_ni`=0 for 3 cycles → `tx_o`=1, `ready_o`=1, `busy_o`=0 throughout; `tx_o` stays 1 for 50 idle cycles after release.
- Single packet: opcode 0x10, result 0xDEADBEEF → sampling mid-bit, the decoded bytes are 10 00 08 00 EF BE AD DE. Every stop bit is 1, and `ready_o` returns after exactly 800 cycles.
- Bit timing: opcode 0x55 → byte-0 data bits alternate 1,0,1,0,… LSB first. Each level lasts exactly 10 cycles, and the start bit falls on the cycle after accept.
- Busy ignore: a second `valid_i` pulse with opcode 0x99 arrives at cycle 200 of a packet → the first packet completes unchanged, and no 0x99 byte appears unless re-presented after `ready_o`.
- Back-to-back: `valid_i` is held high with two results, 0x00000001 then 0x00000002 → 16 bytes decode correctly, with exactly one idle-high cycle between packets.
- Mid-packet reset: `rst_ni`=0 for 1 cycle at cycle 350 → `tx_o`=1 and `ready_o`=1 on the next edge, and a fresh packet afterwards decodes correctly.

Source files
------------

// File: rtl/uart_alu_pkg.sv
// rtl/uart_alu_pkg.sv - shared response header constants, tx FSM states and packet byte mux
package uart_alu_pkg;

  localparam logic [7:0] RespLenLsb   = 8'h08;
  localparam logic [7:0] RespLenMsb   = 8'h00;
  localparam logic [7:0] RespReserved = 8'h00;
  localparam int         RespBytes    = 8;

  typedef enum logic [1:0] {
    TxIdle,
    TxStart,
    TxData,
    TxStop
  } tx_state_e;

  typedef enum logic {
    SeqIdle,
    SeqSend
  } seq_state_e;

  // Byte idx of the response packet; result goes out little-endian.
  function automatic logic [7:0] resp_byte(input logic [7:0]  opcode,
                                           input logic [31:0] result,
                                           input logic [2:0]  idx);
    case (idx)
      3'd0:    resp_byte = opcode;
      3'd1:    resp_byte = RespReserved;
      3'd2:    resp_byte = RespLenLsb;
      3'd3:    resp_byte = RespLenMsb;
      3'd4:    resp_byte = result[7:0];
      3'd5:    resp_byte = result[15:8];
      3'd6:    resp_byte = result[23:16];
      default: resp_byte = result[31:24];
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 serialiser for one byte; accepts the next byte in the last stop-bit cycle
module uart_tx_byte
  import uart_alu_pkg::*;
#(
  parameter int ClksPerBit = 104
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] byte_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       tx_o
);

  localparam int CntW = (ClksPerBit > 2) ? $clog2(ClksPerBit) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(ClksPerBit - 1);

  tx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            tx_q, tx_d;
  logic            bit_end;

  assign bit_end = (cnt_q == CntLast);
  // Ready in the final stop cycle lets the next start bit follow with no gap.
  assign ready_o = (state_q == TxIdle) || ((state_q == TxStop) && bit_end);
  assign tx_o    = tx_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    tx_d      = tx_q;
    if (state_q != TxIdle) begin
      cnt_d = bit_end ? '0 : cnt_q + CntW'(1);
    end
    case (state_q)
      TxIdle: tx_d = 1'b1;
      TxStart: begin
        if (bit_end) begin
          state_d = TxData;
          tx_d    = shreg_q[0];
        end
      end
      TxData: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            state_d   = TxStop;
            bit_idx_d = '0;
            tx_d      = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shreg_d   = shreg_q >> 1;
            tx_d      = shreg_q[1];
          end
        end
      end
      TxStop: begin
        if (bit_end) begin
          state_d = TxIdle;
        end
      end
      default: state_d = TxIdle;
    endcase
    if (valid_i && ready_o) begin
      state_d   = TxStart;
      cnt_d     = '0;
      bit_idx_d = '0;
      shreg_d   = byte_i;
      tx_d      = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= TxIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: rtl/alu_resp_tx.sv
// rtl/alu_resp_tx.sv - frames an ALU opcode/result into an 8-byte response and sends it over UART
module alu_resp_tx
  import uart_alu_pkg::*;
#(
  parameter int ClkFreqHz  = 12_000_000,
  parameter int BaudRate   = 115_200,
  parameter int ClksPerBit = ClkFreqHz / BaudRate
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  opcode_i,
  input  logic [31:0] result_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic        tx_o,
  output logic        busy_o
);

  localparam logic [2:0] LastIdx = 3'(RespBytes - 1);

  seq_state_e  state_q, state_d;
  logic [2:0]  byte_idx_q, byte_idx_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [31:0] result_q, result_d;
  logic        byte_valid, byte_ready;
  logic [7:0]  byte_data;

  assign ready_o = (state_q == SeqIdle) && byte_ready;
  assign busy_o  = !ready_o;

  // Byte 0 is fed straight from the inputs so its start bit begins on the accept edge.
  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    opcode_d   = opcode_q;
    result_d   = result_q;
    byte_valid = 1'b0;
    byte_data  = resp_byte(opcode_q, result_q, byte_idx_q + 3'd1);
    case (state_q)
      SeqIdle: begin
        byte_valid = valid_i;
        byte_data  = resp_byte(opcode_i, result_i, 3'd0);
        if (valid_i && byte_ready) begin
          state_d    = SeqSend;
          byte_idx_d = '0;
          opcode_d   = opcode_i;
          result_d   = result_i;
        end
      end
      SeqSend: begin
        byte_valid = (byte_idx_q != LastIdx);
        if (byte_ready) begin
          if (byte_idx_q == LastIdx) begin
            state_d    = SeqIdle;
            byte_idx_d = '0;
          end else begin
            byte_idx_d = byte_idx_q + 3'd1;
          end
        end
      end
      default: state_d = SeqIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= SeqIdle;
      byte_idx_q <= '0;
      opcode_q   <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      opcode_q   <= opcode_d;
      result_q   <= result_d;
    end
  end

  uart_tx_byte #(
    .ClksPerBit(ClksPerBit)
  ) u_tx_byte (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .byte_i (byte_data),
    .valid_i(byte_valid),
    .ready_o(byte_ready),
    .tx_o   (tx_o)
  );

endmodule

// File: tb/tb_alu_resp_tx.sv
// tb/tb_alu_resp_tx.sv - scoreboard bench: serial decoder checks response bytes, timing and corner cases
module tb_alu_resp_tx;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic [7:0]  opcode_i = '0;
  logic [31:0] result_i = '0;
  logic        valid_i = 1'b0;
  logic        ready_o, tx_o, busy_o;

  always #5 clk = ~clk;

  alu_resp_tx #(
    .ClkFreqHz(1_000_000),
    .BaudRate (100_000)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
    .opcode_i(opcode_i),
    .result_i(result_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .tx_o    (tx_o),
    .busy_o  (busy_o)
  );

  typedef struct {
    logic [7:0]  op;
    logic [31:0] res;
    logic [63:0] pkt;
  } vec_t;

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];
  bit         mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_pkt(input logic [63:0] pkt);
    for (int i = 0; i < 8; i++) exp_q.push_back(pkt[8*i +: 8]);
  endtask

  task automatic wait_ready();
    int w = 0;
    while (ready_o !== 1'b1 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (ready_o !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got=%b expected=1", ready_o);
    end
  endtask

  // Returns on the negedge just after the accepting posedge.
  task automatic accept_pkt(input logic [7:0] op, input logic [31:0] res);
    wait_ready();
    opcode_i = op;
    result_i = res;
    valid_i  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic latency(output int lat);
    lat = 0;
    while (ready_o !== 1'b1 && lat < 3000) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Serial decoder: samples each bit in the middle of its 10-cycle period.
  initial begin
    logic [7:0] d;
    forever begin
      @(negedge clk);
      if (mon_en && rst_ni && tx_o === 1'b0) begin
        repeat (5) @(negedge clk);
        for (int b = 0; b < 8; b++) begin
          repeat (10) @(negedge clk);
          d[b] = tx_o;
        end
        repeat (10) @(negedge clk);
        check("stop_bit", 64'(tx_o), 64'd1);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rx_unexpected: got=%0h expected=none", d);
        end else begin
          check("rx_byte", 64'(d), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[4];
    logic rec[0:801];
    logic rdy[0:801];
    int   lat;
    int   errs;
    logic [7:0] bt_op;
    logic exp_lvl;

    vecs[0] = '{8'h10, 32'hDEADBEEF, 64'hDEADBEEF_00080010};
    vecs[1] = '{8'hFF, 32'h00000000, 64'h00000000_000800FF};
    vecs[2] = '{8'h00, 32'hFFFFFFFF, 64'hFFFFFFFF_00080000};
    vecs[3] = '{8'hA5, 32'h12345678, 64'h12345678_000800A5};

    // Reset held for 3 cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_tx", 64'(tx_o), 64'd1);
      check("rst_ready", 64'(ready_o), 64'd1);
      check("rst_busy", 64'(busy_o), 64'd0);
    end
    rst_ni = 1'b1;
    errs = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx_o !== 1'b1) errs++;
    end
    check("idle_tx_low_cycles", 64'(errs), 64'd0);
    mon_en = 1'b1;

    // Table-driven packets
    for (int v = 0; v < 4; v++) begin
      push_pkt(vecs[v].pkt);
      accept_pkt(vecs[v].op, vecs[v].res);
      check("busy_after_accept", 64'(busy_o), 64'd1);
      latency(lat);
      check("ready_latency", 64'(lat), 64'd800);
    end

    // Bit timing with opcode 0x55
    bt_op = 8'h55;
    push_pkt(64'h00000000_00080055);
    accept_pkt(bt_op, 32'h0);
    rec[0] = tx_o;
    for (int k = 1; k < 100; k++) begin
      @(negedge clk);
      rec[k] = tx_o;
    end
    check("start_after_accept", 64'(rec[0]), 64'd0);
    for (int lvl = 0; lvl < 10; lvl++) begin
      if (lvl == 0) exp_lvl = 1'b0;
      else if (lvl == 9) exp_lvl = 1'b1;
      else exp_lvl = bt_op[lvl-1];
      errs = 0;
      for (int j = 0; j < 10; j++) if (rec[lvl*10+j] !== exp_lvl) errs++;
      check($sformatf("bit_level%0d_errs", lvl), 64'(errs), 64'd0);
    end
    wait_ready();

    // Busy ignore: 0x99 offered mid-packet must not be sent
    push_pkt(64'hCAFEBABE_00080010);
    accept_pkt(8'h10, 32'hCAFEBABE);
    repeat (199) @(negedge clk);
    opcode_i = 8'h99;
    result_i = 32'h99999999;
    valid_i  = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    check("busy_ignore_ready", 64'(ready_o), 64'd0);
    wait_ready();
    repeat (40) @(negedge clk);
    check("busy_ignore_queue", 64'(exp_q.size()), 64'd0);

    // Back-to-back with valid held high
    opcode_i = 8'h21;
    result_i = 32'h00000001;
    valid_i  = 1'b1;
    push_pkt(64'h00000001_00080021);
    @(posedge clk);
    @(negedge clk);
    opcode_i = 8'h22;
    result_i = 32'h00000002;
    push_pkt(64'h00000002_00080022);
    rec[0] = tx_o;
    rdy[0] = ready_o;
    for (int k = 1; k < 802; k++) begin
      @(negedge clk);
      rec[k] = tx_o;
      rdy[k] = ready_o;
      if (k == 801) valid_i = 1'b0;
    end
    check("b2b_stop_high", 64'(rec[799]), 64'd1);
    check("b2b_idle_gap", 64'(rec[800]), 64'd1);
    check("b2b_second_start", 64'(rec[801]), 64'd0);
    check("b2b_ready_gap", 64'(rdy[800]), 64'd1);
    check("b2b_ready_second", 64'(rdy[801]), 64'd0);
    wait_ready();
    repeat (5) @(negedge clk);
    check("b2b_queue", 64'(exp_q.size()), 64'd0);

    // Mid-packet reset, then a fresh packet
    mon_en = 1'b0;
    accept_pkt(8'h10, 32'hCAFEF00D);
    repeat (349) @(negedge clk);
    check("pre_reset_tx", 64'(tx_o), 64'd0);
    rst_ni = 1'b0;
    @(negedge clk);
    check("midrst_tx", 64'(tx_o), 64'd1);
    check("midrst_ready", 64'(ready_o), 64'd1);
    check("midrst_busy", 64'(busy_o), 64'd0);
    rst_ni = 1'b1;
    errs = 0;
    repeat (30) begin
      @(negedge clk);
      if (tx_o !== 1'b1) errs++;
    end
    check("midrst_no_resume", 64'(errs), 64'd0);
    mon_en = 1'b1;
    push_pkt(64'h1234ABCD_00080077);
    accept_pkt(8'h77, 32'h1234ABCD);
    latency(lat);
    check("midrst_fresh_latency", 64'(lat), 64'd800);
    repeat (5) @(negedge clk);

    check("final_queue", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
